uart_rx: RTL and testbench

Asynchronous serial receiver for 8N1 frames. It is the receive-side counterpart to the baud generator and transmitter path. It recovers bit timing from the start-bit falling edge with an internal per-bit down-counter, with no external baud clock. It samples each bit at mid-period, delivers the byte as a one-cycle `valid` strobe, and flags framing errors. It sits between the board RX pin and the byte consumer.

---
 rtl/uart_rx.sv | 108 ++++++++++
 tb/tb_uart_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: start-edge timing recovery with a per-bit down-counter,
// mid-bit sampling, one-cycle valid / frame_err strobes.
module uart_rx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [16:0] BIT_LAST  = 17'(CLKS_PER_BIT - 1);
  localparam logic [16:0] HALF_LAST = 17'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t      state, state_nxt;
  logic        rxd_m, rxd_s;
  logic [16:0] ctr;
  logic [7:0]  sh;
  logic [2:0]  bit_idx;
  logic        sample;
  logic        ld_half, ld_bit, clr_idx, shift_en, stop_good, stop_bad;

  assign sample = (ctr == 17'd0);

  // rxd is asynchronous; only rxd_s is ever used for decisions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rxd_s) state_nxt = START;
      START:     if (sample) state_nxt = rxd_s ? IDLE : DATA;
      DATA:      if (sample && bit_idx == 3'd7) state_nxt = STOP;
      STOP:      if (sample) state_nxt = rxd_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxd_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    ld_half   = 1'b0;
    ld_bit    = 1'b0;
    clr_idx   = 1'b0;
    shift_en  = 1'b0;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE:  ld_half = !rxd_s;
      START: begin
        ld_bit  = sample && !rxd_s;
        clr_idx = sample && !rxd_s;
      end
      DATA: begin
        ld_bit   = sample;
        shift_en = sample;
      end
      STOP: begin
        stop_good = sample && rxd_s;
        stop_bad  = sample && !rxd_s;
      end
      default: ;
    endcase
  end

  // Counter parks at zero outside a frame so a sample event needs a fresh load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr       <= 17'd0;
      sh        <= 8'h00;
      bit_idx   <= 3'd0;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= stop_good;
      frame_err <= stop_bad;
      if (ld_half)           ctr <= HALF_LAST;
      else if (ld_bit)       ctr <= BIT_LAST;
      else if (ctr != 17'd0) ctr <= ctr - 17'd1;
      if (clr_idx) bit_idx <= 3'd0;
      else if (shift_en) begin
        sh      <= {rxd_s, sh[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (stop_good) data <= sh;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: records the driven line per cycle and compares
// every cycle of DUT output against a sample-time model of the 8N1 rules.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int H    = CPB / 2;
  localparam int MAXC = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int ncyc   = 0;
  logic [7:0] carry_data = 8'h00;

  logic       line_q  [MAXC];
  logic       o_valid [MAXC];
  logic       o_ferr  [MAXC];
  logic       o_busy  [MAXC];
  logic [7:0] o_data  [MAXC];
  logic       e_valid [MAXC];
  logic       e_ferr  [MAXC];
  logic       e_busy  [MAXC];
  logic [7:0] e_byte  [MAXC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock of line stimulus; outputs sampled 1 time unit after the edge
  task automatic tick(input logic b);
    @(negedge clk);
    rxd = b;
    @(posedge clk);
    #1;
    if (ncyc >= MAXC) begin
      $display("FAIL trace_overflow: got %0d expected below %0d", ncyc, MAXC);
      $fatal(1);
    end
    line_q[ncyc]  = b;
    o_valid[ncyc] = valid;
    o_ferr[ncyc]  = frame_err;
    o_busy[ncyc]  = busy;
    o_data[ncyc]  = data;
    ncyc++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input int per, input logic stopb);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    for (int j = 0; j < 10; j++)
      for (int k = 0; k < per; k++) tick(f[j]);
  endtask

  // Line level as seen by the receiver's decisions at edge n (two-flop delay, idle-high before)
  function automatic logic rl(input int n);
    return (n < 2) ? 1'b1 : line_q[n-2];
  endfunction

  task automatic mark_busy(input int a, input int b);
    for (int i = a; i < b && i < ncyc; i++) e_busy[i] = 1'b1;
  endtask

  // Reference: walk the recorded line, place sample points by arithmetic from each start edge
  task automatic epoch_check();
    int n, t0, ts, s, e;
    logic [7:0] byt, d;
    for (int i = 0; i < ncyc; i++) begin
      e_valid[i] = 1'b0;
      e_ferr[i]  = 1'b0;
      e_busy[i]  = 1'b0;
      e_byte[i]  = 8'h00;
    end
    n = 0;
    while (n < ncyc) begin
      if (rl(n)) begin
        n++;
        continue;
      end
      t0 = n;
      ts = t0 + H;
      if (ts >= ncyc) begin mark_busy(t0, ncyc); break; end
      if (rl(ts)) begin
        mark_busy(t0, ts);
        n = ts + 1;
        continue;
      end
      s = ts + 9 * CPB;
      if (s >= ncyc) begin mark_busy(t0, ncyc); break; end
      for (int i = 0; i < 8; i++) byt[i] = rl(ts + (i + 1) * CPB);
      if (rl(s)) begin
        mark_busy(t0, s);
        e_valid[s] = 1'b1;
        e_byte[s]  = byt;
        n = s + 1;
      end else begin
        e_ferr[s] = 1'b1;
        e = s + 1;
        while (e < ncyc && !rl(e)) e++;
        mark_busy(t0, e);
        n = e + 1;
      end
    end
    d = carry_data;
    for (int i = 0; i < ncyc; i++) begin
      if (e_valid[i]) d = e_byte[i];
      check($sformatf("valid@%0d", i),     32'(o_valid[i]), 32'(e_valid[i]));
      check($sformatf("frame_err@%0d", i), 32'(o_ferr[i]),  32'(e_ferr[i]));
      check($sformatf("busy@%0d", i),      32'(o_busy[i]),  32'(e_busy[i]));
      check($sformatf("data@%0d", i),      32'(o_data[i]),  32'(d));
    end
    carry_data = d;
    ncyc = 0;
  endtask

  task automatic release_reset();
    rxd = 1'b1;
    @(posedge clk);
    #2;
    rst  = 1'b0;
    ncyc = 0;
  endtask

  initial begin
    logic [9:0] f;
    int mode, len;
    #12;
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    release_reset();
    carry_data = 8'h00;

    idle(5);
    send_frame(8'hA5, CPB, 1'b1);
    idle(20);
    check("single_a5", 32'(data), 32'hA5);

    send_frame(8'h00, CPB, 1'b1);
    send_frame(8'hFF, CPB, 1'b1);
    send_frame(8'h3C, CPB, 1'b1);
    idle(20);
    check("b2b_last", 32'(data), 32'h3C);

    tick(1'b0); tick(1'b0); tick(1'b0);
    idle(20);
    check("glitch_data", 32'(data), 32'h3C);

    send_frame(8'h55, CPB, 1'b0);
    for (int i = 0; i < 40; i++) tick(1'b0);
    idle(30);
    check("ferr_keeps_data", 32'(data), 32'h3C);
    send_frame(8'h81, CPB, 1'b1);
    idle(20);
    check("after_ferr_81", 32'(data), 32'h81);

    // Abort during data bit 4
    f = {1'b1, 8'h5A, 1'b0};
    for (int j = 0; j < 5; j++)
      for (int k = 0; k < ((j == 4) ? H : CPB); k++) tick(f[j]);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_frame_err", 32'(frame_err), 32'h0);
    check("midrst_data", 32'(data), 32'h00);
    epoch_check();
    carry_data = 8'h00;
    repeat (3) @(posedge clk);
    release_reset();

    idle(5);
    send_frame(8'hC3, CPB, 1'b1);
    idle(20);
    check("after_rst_c3", 32'(data), 32'hC3);

    send_frame(8'h96, CPB - 1, 1'b1);
    idle(30);
    send_frame(8'h96, CPB + 1, 1'b1);
    idle(30);
    check("skew_slow_96", 32'(data), 32'h96);

    for (int it = 0; it < 14; it++) begin
      mode = int'($urandom_range(0, 9));
      if (mode == 0) begin
        len = int'($urandom_range(1, 6));
        for (int i = 0; i < len; i++) tick(1'b0);
      end else if (mode == 1) begin
        send_frame(8'($urandom), CPB, 1'b0);
        len = int'($urandom_range(0, 30));
        for (int i = 0; i < len; i++) tick(1'b0);
      end else begin
        send_frame(8'($urandom), int'($urandom_range(CPB - 1, CPB + 1)), 1'b1);
      end
      idle(int'($urandom_range(0, 20)));
    end
    idle(40);
    epoch_check();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
